// File: rtl/key_debounce.sv
// key_debounce: four-channel push-button conditioner.
// Each key is synchronised (2 FF), debounced by a 4-state FSM and emits a
// one-cycle pulse per accepted press, with optional hold-to-repeat.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   key_in     - raw button levels (asynchronous to clk)
//   key_pulse  - registered one-cycle pulse per press / repeat event
//   key_level  - registered debounced state, 1 while pressed
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_pulse,
    output logic [3:0] key_level
);

    localparam int unsigned N_KEYS   = 4;
    localparam int unsigned MAX_AB   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CNT_W    = $clog2(MAX_CNT) + 1;
    localparam bit          REP_EN   = (REPEAT_DELAY != 0);
    localparam int unsigned DEB_LAST = DEBOUNCE_CYCLES - 1;
    // Guarded so a disabled repeat (delay 0) never underflows the threshold.
    localparam int unsigned DLY_LAST = REP_EN ? (REPEAT_DELAY - 1) : 0;
    localparam int unsigned PER_LAST = (REPEAT_PERIOD != 0) ? (REPEAT_PERIOD - 1) : 0;
    localparam bit          PRESS_LVL = ~ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= {N_KEYS{ACTIVE_LOW}};
            r_s2 <= {N_KEYS{ACTIVE_LOW}};
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_first_rep;
        logic             w_first_rep_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;
        logic             r_level;
        logic             w_level_nxt;
        logic             w_pressed;
        logic [CNT_W-1:0] w_rep_thr;

        assign w_pressed = (r_s2[g] == PRESS_LVL);
        // First repeat waits the long delay, later ones the period.
        assign w_rep_thr = r_first_rep ? CNT_W'(DLY_LAST) : CNT_W'(PER_LAST);

        // State, counter and output registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_first_rep <= 1'b0;
                r_pulse     <= 1'b0;
                r_level     <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_first_rep <= w_first_rep_nxt;
                r_pulse     <= w_pulse_nxt;
                r_level     <= w_level_nxt;
            end
        end

        // Next-state and next-output logic.
        always_comb begin
            w_state_nxt     = r_state;
            w_cnt_nxt       = r_cnt;
            w_first_rep_nxt = r_first_rep;
            w_pulse_nxt     = 1'b0;
            w_level_nxt     = r_level;
            case (r_state)
                ST_IDLE: begin
                    w_level_nxt = 1'b0;
                    if (w_pressed) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_pressed) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(DEB_LAST)) begin
                        w_state_nxt     = ST_PRESSED;
                        w_pulse_nxt     = 1'b1;
                        w_level_nxt     = 1'b1;
                        w_cnt_nxt       = '0;
                        w_first_rep_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_pressed) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (REP_EN) begin
                        if (r_cnt == w_rep_thr) begin
                            w_pulse_nxt     = 1'b1;
                            w_cnt_nxt       = '0;
                            w_first_rep_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A re-press during release restarts the repeat delay silently.
                    if (w_pressed) begin
                        w_state_nxt     = ST_PRESSED;
                        w_cnt_nxt       = '0;
                        w_first_rep_nxt = 1'b1;
                    end else if (r_cnt == CNT_W'(DEB_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_level_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign key_pulse[g] = r_pulse;
        assign key_level[g] = r_level;
    end

endmodule
